// File: rtl/sipo_deser_rx_if.sv
// sipo_deser_rx_if
// Serial-in / word-out bus of the SIPO receive stage.
//   serial_in, serial_en, frame_start : bit stream from the upstream PISO
//   data_out, data_valid              : assembled word towards the consumer
//   data_ready                        : consumer accept
// Modports: slave = the receiver, master = the environment driving it.
interface sipo_deser_rx_if #(
  parameter int WIDTH = 16
);
  logic             serial_in;
  logic             serial_en;
  logic             frame_start;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport slave (
    input  serial_in,
    input  serial_en,
    input  frame_start,
    input  data_ready,
    output data_out,
    output data_valid
  );

  modport master (
    output serial_in,
    output serial_en,
    output frame_start,
    output data_ready,
    input  data_out,
    input  data_valid
  );
endinterface

// File: rtl/sipo_deser_rx.sv
// sipo_deser_rx
// Serial-to-parallel receive stage. Collects WIDTH strobed bits into a word,
// aligned by frame_start, and presents it in a one-word holding register.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset
//   bus      : sipo_deser_rx_if.slave (serial input + valid/ready word output)
//   busy     : receiver is in SHIFT state
//   bit_cnt  : bits collected for the current word
//   sync_err : one-cycle pulse when frame_start realigns a partial word
//   overrun  : sticky, a completed word was dropped because the holder was full
//   clr_ovr  : synchronous clear of overrun (a same-edge set wins)
module sipo_deser_rx #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sipo_deser_rx_if.slave       bus,
  output logic                 busy,
  output logic [CW-1:0]        bit_cnt,
  output logic                 sync_err,
  output logic                 overrun,
  input  logic                 clr_ovr
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] shift_r, shift_nxt_s, base_s, word_s;
  logic [WIDTH-1:0] data_r, data_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s, cnt_cur_s;
  logic             valid_r, valid_nxt_s;
  logic             ovr_r, ovr_nxt_s;
  logic             sync_r, sync_nxt_s;
  logic             busy_r;
  logic             take_s, complete_s;

  // Shift direction: with MSB_FIRST the earliest bit walks up to the MSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign word_s = bus.serial_in;
    end else if (MSB_FIRST) begin : g_msb
      assign word_s = {base_s[WIDTH-2:0], bus.serial_in};
    end else begin : g_lsb
      assign word_s = {bus.serial_in, base_s[WIDTH-1:1]};
    end
  endgenerate

  // Bit acceptance: frame_start restarts the word from an empty register.
  always_comb begin
    take_s    = bus.serial_en & ((state_r == SHIFT) | bus.frame_start);
    base_s    = shift_r;
    cnt_cur_s = cnt_r;
    if (bus.frame_start) begin
      base_s    = '0;
      cnt_cur_s = '0;
    end else begin
      base_s    = shift_r;
      cnt_cur_s = cnt_r;
    end
    complete_s = take_s & (cnt_cur_s == LAST_CNT);
  end

  // Next-state, counter, holding register and error flags.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    ovr_nxt_s   = ovr_r;
    sync_nxt_s  = 1'b0;

    case (state_r)
      IDLE, SHIFT: begin
        if (take_s) begin
          state_nxt_s = SHIFT;
          shift_nxt_s = word_s;
          cnt_nxt_s   = complete_s ? '0 : (cnt_cur_s + CNT_ONE);
          // Only a realignment of a partially collected word is an error.
          sync_nxt_s  = bus.frame_start & (state_r == SHIFT) & (cnt_r != '0);
        end else begin
          state_nxt_s = state_r;
          shift_nxt_s = shift_r;
          cnt_nxt_s   = cnt_r;
          sync_nxt_s  = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // A full holder that is not being drained this edge drops the new word.
    if (complete_s && valid_r && !bus.data_ready) begin
      ovr_nxt_s = 1'b1;
    end else if (clr_ovr) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = ovr_r;
    end

    if (complete_s && (!valid_r || bus.data_ready)) begin
      data_nxt_s  = word_s;
      valid_nxt_s = 1'b1;
    end else if (valid_r && bus.data_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
      sync_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      cnt_r   <= cnt_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      ovr_r   <= ovr_nxt_s;
      sync_r  <= sync_nxt_s;
      busy_r  <= (state_nxt_s == SHIFT);
    end
  end

  assign bus.data_out   = data_r;
  assign bus.data_valid = valid_r;
  assign busy           = busy_r;
  assign bit_cnt        = cnt_r;
  assign sync_err       = sync_r;
  assign overrun        = ovr_r;

endmodule

// File: tb/tb_sipo_deser_rx.sv
// tb_sipo_deser_rx
// Directed bench for sipo_deser_rx (WIDTH=16, MSB first).
module tb_sipo_deser_rx;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] bit_cnt;
  logic       sync_err;
  logic       overrun;
  logic       clr_ovr;
  int         checks   = 0;
  int         failures = 0;

  sipo_deser_rx_if #(.WIDTH(W)) bus ();

  sipo_deser_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .bit_cnt  (bit_cnt),
    .sync_err (sync_err),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send bits hi..lo of w, MSB first; optional frame_start on bit hi and idle gap between bits.
  task automatic send_range(input logic [15:0] w, input int hi, input int lo,
                            input bit fs_first, input bit gap);
    for (int i = hi; i >= lo; i--) begin
      bus.serial_in   = w[i];
      bus.serial_en   = 1'b1;
      bus.frame_start = fs_first && (i == hi);
      tick();
      bus.serial_en   = 1'b0;
      bus.frame_start = 1'b0;
      if (gap && (i > lo)) tick();
    end
  endtask

  initial begin
    rst             = 1'b0;
    clr_ovr         = 1'b0;
    bus.serial_in   = 1'b0;
    bus.serial_en   = 1'b0;
    bus.frame_start = 1'b0;
    bus.data_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_data",  32'(bus.data_out), 32'h0);
    check("rst_valid", 32'(bus.data_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_cnt",   32'(bit_cnt), 32'h0);
    check("rst_sync",  32'(sync_err), 32'h0);
    check("rst_ovr",   32'(overrun), 32'h0);

    // Basic word
    rst = 1'b1;
    bus.data_ready = 1'b1;
    send_range(16'hA5C3, 15, 0, 1'b1, 1'b0);
    check("basic_data",  32'(bus.data_out), 32'hA5C3);
    check("basic_valid", 32'(bus.data_valid), 32'h1);
    check("basic_cnt",   32'(bit_cnt), 32'h0);
    check("basic_busy",  32'(busy), 32'h1);
    tick();
    check("basic_valid_1cyc", 32'(bus.data_valid), 32'h0);

    // Gapped 0x1234 with aligned frame_start, then 0xBEEF back-to-back
    send_range(16'h1234, 15, 15, 1'b1, 1'b0);
    check("aligned_fs_nosync", 32'(sync_err), 32'h0);
    check("aligned_fs_cnt",    32'(bit_cnt), 32'h1);
    tick();
    send_range(16'h1234, 14, 8, 1'b0, 1'b1);
    check("gap_cnt_mid", 32'(bit_cnt), 32'd8);
    tick();
    send_range(16'h1234, 7, 0, 1'b0, 1'b1);
    check("gap_data",  32'(bus.data_out), 32'h1234);
    check("gap_valid", 32'(bus.data_valid), 32'h1);
    check("gap_cnt0",  32'(bit_cnt), 32'h0);
    send_range(16'hBEEF, 15, 0, 1'b0, 1'b0);
    check("b2b_data",  32'(bus.data_out), 32'hBEEF);
    check("b2b_valid", 32'(bus.data_valid), 32'h1);
    check("b2b_cnt0",  32'(bit_cnt), 32'h0);
    tick();
    check("b2b_drain", 32'(bus.data_valid), 32'h0);

    // Backpressure and overrun
    bus.data_ready = 1'b0;
    send_range(16'h00FF, 15, 0, 1'b1, 1'b0);
    check("bp_first_data", 32'(bus.data_out), 32'h00FF);
    check("bp_first_ovr",  32'(overrun), 32'h0);
    send_range(16'hFF00, 15, 0, 1'b0, 1'b0);
    check("ovr_data_held", 32'(bus.data_out), 32'h00FF);
    check("ovr_valid",     32'(bus.data_valid), 32'h1);
    check("ovr_set",       32'(overrun), 32'h1);
    tick();
    check("ovr_sticky", 32'(overrun), 32'h1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared",    32'(overrun), 32'h0);
    check("ovr_data_still", 32'(bus.data_out), 32'h00FF);
    bus.data_ready = 1'b1;
    tick();
    check("bp_drain", 32'(bus.data_valid), 32'h0);

    // Simultaneous accept and completion
    bus.data_ready = 1'b0;
    send_range(16'h1111, 15, 0, 1'b1, 1'b0);
    send_range(16'h2222, 15, 1, 1'b0, 1'b0);
    check("sim_hold_data", 32'(bus.data_out), 32'h1111);
    bus.data_ready = 1'b1;
    send_range(16'h2222, 0, 0, 1'b0, 1'b0);
    check("sim_data",  32'(bus.data_out), 32'h2222);
    check("sim_valid", 32'(bus.data_valid), 32'h1);
    check("sim_ovr",   32'(overrun), 32'h0);
    tick();
    check("sim_drain", 32'(bus.data_valid), 32'h0);

    // Mid-word resync
    send_range(16'hAA00, 15, 9, 1'b1, 1'b0);
    check("resync_cnt7",  32'(bit_cnt), 32'd7);
    check("resync_pre",   32'(sync_err), 32'h0);
    send_range(16'hC0DE, 15, 15, 1'b1, 1'b0);
    check("resync_pulse", 32'(sync_err), 32'h1);
    check("resync_cnt1",  32'(bit_cnt), 32'h1);
    send_range(16'hC0DE, 14, 14, 1'b0, 1'b0);
    check("resync_1cyc",  32'(sync_err), 32'h0);
    send_range(16'hC0DE, 13, 0, 1'b0, 1'b0);
    check("resync_data",  32'(bus.data_out), 32'hC0DE);
    check("resync_valid", 32'(bus.data_valid), 32'h1);
    tick();

    // Reset with a pending word and a partial word
    bus.data_ready = 1'b0;
    send_range(16'h5A5A, 15, 0, 1'b1, 1'b0);
    send_range(16'h3C3C, 15, 7, 1'b0, 1'b0);
    check("pre_rst_cnt9",  32'(bit_cnt), 32'd9);
    check("pre_rst_valid", 32'(bus.data_valid), 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mrst_data",  32'(bus.data_out), 32'h0);
    check("mrst_valid", 32'(bus.data_valid), 32'h0);
    check("mrst_busy",  32'(busy), 32'h0);
    check("mrst_cnt",   32'(bit_cnt), 32'h0);
    check("mrst_sync",  32'(sync_err), 32'h0);
    check("mrst_ovr",   32'(overrun), 32'h0);
    send_range(16'hFFFF, 15, 0, 1'b0, 1'b0);
    check("idle_ignore_cnt",   32'(bit_cnt), 32'h0);
    check("idle_ignore_busy",  32'(busy), 32'h0);
    check("idle_ignore_valid", 32'(bus.data_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
